lane_alu_engine: RTL and testbench

Parametrised streaming lane-ALU engine, successor to the single-mode add stage between the AXI read master and the AXI write master. Each accepted beat is split into `DATA_W/LANE_W` lanes; every lane is combined with a per-operation operand (add, subtract, xor or pass) and buffered in an internal FIFO. The block gates acceptance to exactly `words_num` beats, issues a one-cycle write-master request once the whole transfer is buffered, then drains the FIFO with `tlast` on the final beat and signals completion.

---
 rtl/lane_alu_engine.sv | 155 +++++++++++++++
 tb/tb_lane_alu_engine.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lane_alu_engine.sv
// Streaming lane-ALU: applies one operation to every lane of each accepted beat,
// buffers a whole transfer, requests the write master once, then drains it.
module lane_alu_engine #(
  parameter int DATA_W = 512,
  parameter int LANE_W = 128,
  parameter int AW     = 10
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              op_start,
  input  logic [1:0]        op_code,
  input  logic [LANE_W-1:0] operand,
  input  logic [AW:0]       words_num,
  input  logic [63:0]       write_addr,
  output logic              busy,
  output logic              op_done,
  input  logic              axis_slv_rmst_tvalid,
  input  logic [DATA_W-1:0] axis_slv_rmst_tdata,
  output logic              axis_slv_rmst_tready,
  output logic              axis_mst_wmst_tvalid,
  input  logic              axis_mst_wmst_tready,
  output logic [DATA_W-1:0] axis_mst_wmst_tdata,
  output logic              axis_mst_wmst_tlast,
  output logic              wmst_req,
  output logic [63:0]       wmst_xfer_addr,
  output logic [63:0]       wmst_xfer_size
);
  localparam int LANES = DATA_W / LANE_W;
  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FILL  = 2'd1;
  localparam logic [1:0] ST_REQ   = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  logic [1:0]        state_reg, state_next;
  logic              op_done_reg, op_done_next;
  logic [1:0]        op_code_reg;
  logic [LANE_W-1:0] operand_reg;
  logic [AW:0]       words_num_reg, words_num_sat;
  logic [63:0]       xfer_addr_reg;
  logic [AW:0]       in_cnt_reg, out_cnt_reg, in_cnt_inc, out_cnt_inc;

  logic [DATA_W-1:0] fifo_mem [DEPTH];
  logic [DATA_W-1:0] head_reg, push_data;
  logic [AW-1:0]     wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
  logic [AW:0]       fifo_cnt_reg;
  logic              push, pop;

  assign push = axis_slv_rmst_tvalid && axis_slv_rmst_tready;
  assign pop  = axis_mst_wmst_tvalid && axis_mst_wmst_tready;

  assign in_cnt_inc    = in_cnt_reg + CNT_ONE;
  assign out_cnt_inc   = out_cnt_reg + CNT_ONE;
  assign words_num_sat = (words_num > DEPTH_W) ? DEPTH_W : words_num;

  // Each lane has its own LANE_W-bit datapath, so carries never cross a lane boundary.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [LANE_W-1:0] lane_in, lane_out;
    assign lane_in  = axis_slv_rmst_tdata[gi*LANE_W +: LANE_W];
    assign lane_out = (op_code_reg == 2'd0) ? lane_in + operand_reg :
                      (op_code_reg == 2'd1) ? lane_in - operand_reg :
                      (op_code_reg == 2'd2) ? lane_in ^ operand_reg : lane_in;
    assign push_data[gi*LANE_W +: LANE_W] = lane_out;
  end

  always_comb begin
    state_next   = state_reg;
    op_done_next = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (op_start) begin
          if (words_num == '0) op_done_next = 1'b1;
          else                 state_next   = ST_FILL;
        end
      end
      ST_FILL:  if (push && in_cnt_inc == words_num_reg) state_next = ST_REQ;
      ST_REQ:   state_next = ST_DRAIN;
      ST_DRAIN: begin
        if (pop && out_cnt_inc == words_num_reg) begin
          state_next   = ST_IDLE;
          op_done_next = 1'b1;
        end
      end
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_reg     <= ST_IDLE;
      op_done_reg   <= 1'b0;
      op_code_reg   <= '0;
      operand_reg   <= '0;
      words_num_reg <= '0;
      xfer_addr_reg <= '0;
      in_cnt_reg    <= '0;
      out_cnt_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      op_done_reg <= op_done_next;
      if (state_reg == ST_IDLE && op_start) begin
        op_code_reg   <= op_code;
        operand_reg   <= operand;
        words_num_reg <= words_num_sat;
        xfer_addr_reg <= write_addr;
        in_cnt_reg    <= '0;
        out_cnt_reg   <= '0;
      end else begin
        if (push) in_cnt_reg  <= in_cnt_inc;
        if (pop)  out_cnt_reg <= out_cnt_inc;
      end
    end
  end

  assign rd_ptr_next = pop ? rd_ptr_reg + PTR_ONE : rd_ptr_reg;

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      fifo_cnt_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      rd_ptr_reg <= rd_ptr_next;
      case ({push, pop})
        2'b10:   fifo_cnt_reg <= fifo_cnt_reg + CNT_ONE;
        2'b01:   fifo_cnt_reg <= fifo_cnt_reg - CNT_ONE;
        default: fifo_cnt_reg <= fifo_cnt_reg;
      endcase
    end
  end

  // Registered-read RAM; a write to the next head slot is forwarded so a push
  // into an empty FIFO is visible at the head one cycle later.
  always_ff @(posedge aclk) begin
    if (push) fifo_mem[wr_ptr_reg] <= push_data;
    if (push && wr_ptr_reg == rd_ptr_next) head_reg <= push_data;
    else                                   head_reg <= fifo_mem[rd_ptr_next];
  end

  assign busy                 = (state_reg != ST_IDLE);
  assign op_done              = op_done_reg;
  assign axis_slv_rmst_tready = (state_reg == ST_FILL);
  assign wmst_req             = (state_reg == ST_REQ);
  assign axis_mst_wmst_tvalid = (state_reg == ST_DRAIN) && (fifo_cnt_reg != '0);
  assign axis_mst_wmst_tdata  = head_reg;
  assign axis_mst_wmst_tlast  = (state_reg == ST_DRAIN) && (out_cnt_reg == words_num_reg - CNT_ONE);
  assign wmst_xfer_addr       = xfer_addr_reg;
  assign wmst_xfer_size       = 64'(words_num_reg) * 64'(DATA_W / 8);

endmodule

// File: tb/tb_lane_alu_engine.sv
// Scoreboard bench for lane_alu_engine: the driver queues expected output beats
// from a lane-arithmetic model; a negedge monitor pops and compares them.
module tb_lane_alu_engine;
  localparam int DATA_W = 512;
  localparam int LANE_W = 128;
  localparam int AW     = 10;
  localparam int LANES  = DATA_W / LANE_W;
  localparam int DEPTH  = 1 << AW;
  localparam int CW     = DATA_W + 8;

  logic              aclk = 1'b0;
  logic              areset = 1'b1;
  logic              op_start = 1'b0;
  logic [1:0]        op_code = '0;
  logic [LANE_W-1:0] operand = '0;
  logic [AW:0]       words_num = '0;
  logic [63:0]       write_addr = '0;
  logic              busy, op_done;
  logic              in_tvalid = 1'b0;
  logic [DATA_W-1:0] in_tdata = '0;
  logic              in_tready;
  logic              out_tvalid;
  logic              out_tready = 1'b0;
  logic [DATA_W-1:0] out_tdata;
  logic              out_tlast;
  logic              wmst_req;
  logic [63:0]       xfer_addr, xfer_size;

  int checks = 0;
  int errors = 0;
  int req_cnt = 0;
  int done_cnt = 0;
  int pop_cnt = 0;
  int out_mode = 0;
  int op_num = 0;
  logic [DATA_W:0]   exp_q[$];
  logic [1:0]        cur_op;
  logic [LANE_W-1:0] cur_k;
  int                cur_words;
  logic [63:0]       cur_addr;

  lane_alu_engine #(.DATA_W(DATA_W), .LANE_W(LANE_W), .AW(AW)) dut (
    .aclk(aclk), .areset(areset), .op_start(op_start), .op_code(op_code),
    .operand(operand), .words_num(words_num), .write_addr(write_addr),
    .busy(busy), .op_done(op_done),
    .axis_slv_rmst_tvalid(in_tvalid), .axis_slv_rmst_tdata(in_tdata),
    .axis_slv_rmst_tready(in_tready),
    .axis_mst_wmst_tvalid(out_tvalid), .axis_mst_wmst_tready(out_tready),
    .axis_mst_wmst_tdata(out_tdata), .axis_mst_wmst_tlast(out_tlast),
    .wmst_req(wmst_req), .wmst_xfer_addr(xfer_addr), .wmst_xfer_size(xfer_size)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Each lane is an independent LANE_W-bit number; arithmetic wraps modulo 2**LANE_W.
  function automatic logic [DATA_W-1:0] model(input logic [DATA_W-1:0] d, input logic [1:0] op,
                                              input logic [LANE_W-1:0] k);
    logic [DATA_W-1:0] r;
    logic [LANE_W-1:0] a;
    r = '0;
    for (int l = 0; l < LANES; l++) begin
      a = d[l*LANE_W +: LANE_W];
      case (op)
        2'd0:    r[l*LANE_W +: LANE_W] = a + k;
        2'd1:    r[l*LANE_W +: LANE_W] = a - k;
        2'd2:    r[l*LANE_W +: LANE_W] = a ^ k;
        default: r[l*LANE_W +: LANE_W] = a;
      endcase
    end
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] gen(input int mode);
    logic [DATA_W-1:0] d;
    d = '0;
    for (int l = 0; l < LANES; l++) d[l*LANE_W +: LANE_W] = (mode == 1) ? {LANE_W{1'b1}} : LANE_W'(3);
    if (mode == 0) for (int w = 0; w < DATA_W / 32; w++) d[w*32 +: 32] = $urandom;
    return d;
  endfunction

  function automatic logic [LANE_W-1:0] rand_lane();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Output-side ready: 0 always ready, 1 random stalls, 2 held low.
  initial begin
    forever begin
      @(posedge aclk);
      #1;
      case (out_mode)
        0:       out_tready = 1'b1;
        1:       out_tready = ($urandom_range(0, 3) != 0);
        default: out_tready = 1'b0;
      endcase
    end
  end

  initial begin
    logic            prev_hold;
    logic [DATA_W:0] prev_out, e;
    prev_hold = 1'b0;
    prev_out  = '0;
    forever begin
      @(negedge aclk);
      if (wmst_req) req_cnt++;
      if (op_done)  done_cnt++;
      if (areset) begin
        prev_hold = 1'b0;
      end else begin
        if (prev_hold) chk("out_hold", {out_tvalid, out_tlast, out_tdata}, {1'b1, prev_out});
        if (out_tvalid && out_tready) begin
          pop_cnt++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL out_extra: got beat 0x%0h, expected no beat", out_tdata);
          end else begin
            e = exp_q.pop_front();
            chk("out_data", out_tdata, e[DATA_W-1:0]);
            chk("out_last", out_tlast, e[DATA_W]);
          end
        end
        prev_hold = out_tvalid && !out_tready;
        prev_out  = {out_tlast, out_tdata};
      end
    end
  end

  task automatic start_op(input logic [1:0] op, input logic [LANE_W-1:0] k, input int words,
                          input logic [63:0] addr);
    int sat;
    sat       = (words > DEPTH) ? DEPTH : words;
    cur_op    = op;
    cur_k     = k;
    cur_words = sat;
    cur_addr  = addr;
    req_cnt   = 0;
    done_cnt  = 0;
    pop_cnt   = 0;
    op_code   = op;
    operand   = k;
    words_num = (AW+1)'(words);
    write_addr = addr;
    op_start  = 1'b1;
    @(posedge aclk);
    #1;
    op_start = 1'b0;
    chk("busy_T1", busy, sat != 0);
    chk("tready_T1", in_tready, sat != 0);
    chk("done_T1", op_done, sat == 0);
    chk("xfer_addr_T1", xfer_addr, addr);
    chk("xfer_size_T1", xfer_size, 64'(sat) * 64);
  endtask

  task automatic feed_op(input int mode, input bit in_stall, input bit ign);
    int   i, cyc;
    logic hs;
    bit   ign_done;
    i = 0;
    cyc = 0;
    ign_done = 1'b0;
    in_tdata  = gen(mode);
    in_tvalid = !in_stall || ($urandom_range(0, 2) != 0);
    while (i < cur_words && cyc < 20000) begin
      @(negedge aclk);
      hs = in_tvalid && in_tready;
      if (hs) exp_q.push_back({i == cur_words - 1, model(in_tdata, cur_op, cur_k)});
      @(posedge aclk);
      #1;
      cyc++;
      op_start = 1'b0;
      if (hs) begin
        i++;
        in_tdata = gen(mode);
      end
      if (!in_tvalid || hs) in_tvalid = (i < cur_words) && (!in_stall || ($urandom_range(0, 2) != 0));
      if (ign && !ign_done && i == 2) begin
        op_start   = 1'b1;
        write_addr = ~cur_addr;
        words_num  = (AW+1)'(7);
        op_code    = ~cur_op;
        ign_done   = 1'b1;
      end
    end
    op_start = 1'b0;
    if (i < cur_words) begin
      checks++;
      errors++;
      $display("FAIL feed_timeout: got %0d beats accepted, expected %0d", i, cur_words);
    end else begin
      chk("wmst_req_F1", wmst_req, 1);
      chk("tvalid_F1", out_tvalid, 0);
      in_tvalid = 1'b1;
      in_tdata  = gen(0);
      repeat (3) begin
        @(negedge aclk);
        chk("no_extra_in", in_tready, 0);
        @(posedge aclk);
        #1;
      end
      in_tvalid = 1'b0;
    end
  endtask

  task automatic finish_op();
    int cyc;
    cyc = 0;
    while (cyc < 20000) begin
      @(negedge aclk);
      if (op_done) break;
      cyc++;
    end
    if (!op_done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no op_done, expected pulse within 20000 cycles");
    end else begin
      chk("busy_at_done", busy, 0);
    end
    @(posedge aclk);
    #1;
    chk("done_one_cycle", op_done, 0);
    chk("queue_empty", exp_q.size(), 0);
    chk("req_count", req_cnt, 1);
    chk("done_count", done_cnt, 1);
    chk("xfer_addr_hold", xfer_addr, cur_addr);
    chk("xfer_size_hold", xfer_size, 64'(cur_words) * 64);
    op_num++;
    $display("op %0d: op_code=%0d beats=%0d popped=%0d", op_num, cur_op, cur_words, pop_cnt);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: got no finish, expected end of run");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", op_done, 0);
    chk("rst_req", wmst_req, 0);
    chk("rst_tready", in_tready, 0);
    chk("rst_tvalid", out_tvalid, 0);
    chk("rst_tlast", out_tlast, 0);
    chk("rst_addr", xfer_addr, 0);
    chk("rst_size", xfer_size, 0);
    areset = 1'b0;
    @(posedge aclk);
    #1;

    // add 1 to all-ones lanes: every lane wraps to zero
    out_mode = 0;
    start_op(2'd0, LANE_W'(1), 4, 64'h0000_0000_8000_0000);
    feed_op(1, 1'b0, 1'b0);
    finish_op();

    // 3 - 5 wraps to 2**128 - 2
    out_mode = 1;
    start_op(2'd1, LANE_W'(5), 4, 64'h1234_5678_0000_0040);
    feed_op(2, 1'b0, 1'b0);
    finish_op();

    start_op(2'd2, {16{8'hA5}}, 6, 64'hDEAD_BEEF_0000_1000);
    feed_op(0, 1'b1, 1'b0);
    finish_op();

    start_op(2'd3, rand_lane(), 5, 64'h0000_0000_0000_2000);
    feed_op(0, 1'b1, 1'b0);
    finish_op();

    // full depth with stalls on both sides
    start_op(2'($urandom_range(0, 3)), rand_lane(), DEPTH, 64'h0000_0001_0000_0000);
    feed_op(0, 1'b1, 1'b0);
    finish_op();

    // zero-length transfer completes at once without a write request
    start_op(2'd0, LANE_W'(9), 0, 64'h0000_0000_0000_3000);
    repeat (3) begin
      @(negedge aclk);
      chk("zero_tready", in_tready, 0);
      chk("zero_req", wmst_req, 0);
    end
    @(posedge aclk);
    #1;
    chk("zero_done_count", done_cnt, 1);
    chk("zero_req_count", req_cnt, 0);

    // op_start during FILL must be ignored
    out_mode = 0;
    start_op(2'd2, rand_lane(), 6, 64'h0000_0000_0000_4000);
    feed_op(0, 1'b1, 1'b1);
    finish_op();

    // reset in DRAIN after two of eight beats
    out_mode = 2;
    start_op(2'd0, rand_lane(), 8, 64'h0000_0000_0000_5000);
    feed_op(0, 1'b0, 1'b0);
    out_mode = 0;
    cyc = 0;
    while (pop_cnt < 2 && cyc < 200) begin
      @(posedge aclk);
      #1;
      cyc++;
    end
    chk("pops_before_reset", pop_cnt, 2);
    areset     = 1'b1;
    out_mode   = 2;
    out_tready = 1'b0;
    @(posedge aclk);
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", op_done, 0);
    chk("mid_rst_req", wmst_req, 0);
    chk("mid_rst_tready", in_tready, 0);
    chk("mid_rst_tvalid", out_tvalid, 0);
    chk("mid_rst_tlast", out_tlast, 0);
    chk("mid_rst_addr", xfer_addr, 0);
    chk("mid_rst_size", xfer_size, 0);
    areset = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge aclk);
    #1;
    chk("mid_rst_no_done", done_cnt, 0);

    out_mode = 1;
    start_op(2'd1, rand_lane(), 3, 64'h0000_0000_0000_6000);
    feed_op(0, 1'b1, 1'b0);
    finish_op();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
